pipe_if_stage: RTL and testbench
================================

// Module: pipe_if_stage
// PURPOSE
//  Instruction-fetch stage: producer side of the IF/ID interface. Owns the PC,
//  fetches from instruction memory via a req/ack handshake and presents
//  {pc4, inst} to the IF/ID register, which latches them when nostall=1.
//  Applies branch/jump redirects from decode with one delay slot; inserts NOP
//  bubbles while memory has not answered.
// PARAMETERS
//  RESET_PC  32'h0040_0000  PC value after reset
//  NOP_INST  32'h0000_0000  instruction emitted as a bubble
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-low reset
//  nostall     in   1   IF/ID accepts {pc4,inst} this edge (same signal as IR)
//  pcsource    in   2   from decode: 00 pc+4, 01 branch, 10 jr, 11 jump
//  bpc         in   32  branch target (pcsource=01)
//  rpc         in   32  register target (pcsource=10)
//  jpc         in   32  jump target (pcsource=11)
//  imem_req    out  1   fetch request
//  imem_addr   out  32  fetch address (= pc)
//  imem_ack    in   1   imem_rdata valid this cycle
//  imem_rdata  in   32  fetched instruction
//  pc4         out  32  pc+4 of the presented instruction
//  inst        out  32  presented instruction or NOP_INST
// BEHAVIOUR
//  - Reset (rst=0, async): pc=RESET_PC, state=FETCH, hold buffer=NOP_INST,
//    pend_valid=0, pend_target=0. Outputs: imem_req=1, imem_addr=RESET_PC,
//    pc4=RESET_PC+4, inst=NOP_INST (until ack).
//  - States: FETCH (imem_req=1), HOLD (imem_req=0, output from buffer).
//  - FETCH, imem_ack=0: inst=NOP_INST, pc4=pc+4; pc unchanged; imem_addr stable.
//  - FETCH, imem_ack=1: inst=imem_rdata, pc4=pc+4 same cycle (zero extra latency).
//    nostall=1 -> consumed: pc<=npc, stay FETCH. nostall=0 -> buffer<=imem_rdata,
//    go HOLD.
//  - HOLD: inst=buffer, pc4=pc+4. nostall=1 -> consumed: pc<=npc, go FETCH.
//  - npc on consume: pcsource!=00 -> selected target; else pend_valid ->
//    pend_target; else pc+4. pend_valid cleared on every consume.
//  - Redirect capture: pcsource!=00 with nostall=1 but no consume this edge ->
//    pend_target<=selected target, pend_valid<=1. Live pcsource beats pend.
//  - Delay slot: instruction fetched when the redirect arrives is always
//    delivered; the target is the fetch after it. No squash logic here.
//  - pcsource is honoured only when nostall=1 (decode stalled -> ignored).
//  - Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0. No alignment check.
//  - Reset mid-fetch: state cleared async; memory side must drop outstanding
//    requests on the same reset (no stale ack after release).
// STRUCTURE
//  - Shared package: PCSRC_SEQ/BR/JR/J encodings, NOP_INST, RESET_PC default.
//  - Sub-module pipe_npc_mux: combinational 4:1 target select + pend priority.
//  - State, pc, buffer, pend registers local; no other hierarchy.
// TESTING
//  1 Reset, ack every cycle, nostall=1 -> imem_addr 0x00400000,04,08..;
//    pc4 0x00400004,08,0C; first edge after rst release fetches RESET_PC.
//  2 Ack delayed 3 cycles -> inst=NOP for 3 cycles, imem_addr held 0x00400008,
//    then rdata presented with pc4=0x0040000C.
//  3 Ack with nostall=0 for 2 cycles -> HOLD, imem_req=0, inst stays 0x8C220004;
//    nostall=1 -> pc advances by 4, FETCH resumes.
//  4 pcsource=01, bpc=0x00400100 with ack same cycle -> next imem_addr
//    0x00400100; with ack 2 cycles late -> delay slot delivered, then 0x00400100.
//  5 pcsource=10 while nostall=0 -> ignored, sequential fetch continues.
//  6 rst pulsed low while in HOLD -> next cycle imem_addr=0x00400000, inst=NOP,
//    pend_valid=0; pc 0xFFFFFFFC consumed -> next imem_addr 0x00000000.

Source files
------------

// File: rtl/pipe_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: PC-source encodings,
// FSM state type and default reset PC / bubble instruction.
package pipe_if_stage_pkg;

  // pcsource encodings driven by decode
  localparam logic [1:0] PCSRC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target (bpc)
  localparam logic [1:0] PCSRC_JR  = 2'b10;  // register target (rpc)
  localparam logic [1:0] PCSRC_J   = 2'b11;  // jump target (jpc)

  // Defaults for the top-level parameters
  localparam logic [31:0] IF_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] IF_NOP_INST = 32'h0000_0000;

  // FETCH: request outstanding to memory; HOLD: answered but not yet consumed
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } if_state_e;

endpackage

// File: rtl/pipe_if_stage_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
interface pipe_if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  // Fetch stage drives the request side
  modport master (output req, output addr, input ack, input rdata);
  // Instruction memory answers
  modport slave (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pipe_npc_mux.sv
// Next-PC selection: live redirect from decode first, then a remembered
// (pending) redirect, then sequential pc+4.
module pipe_npc_mux
  import pipe_if_stage_pkg::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [31:0] pc,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  output logic        redirect,
  output logic [31:0] sel_target,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;

  assign seq_pc = pc + 32'd4;  // wraps modulo 2^32

  // Select the live redirect target, then apply live > pending > sequential
  always_comb begin
    redirect   = (pcsource != PCSRC_SEQ);
    sel_target = seq_pc;
    case (pcsource)
      PCSRC_BR: sel_target = bpc;
      PCSRC_JR: sel_target = rpc;
      PCSRC_J:  sel_target = jpc;
      default:  sel_target = seq_pc;
    endcase
    if (redirect) begin
      npc = sel_target;
    end else if (pend_valid) begin
      npc = pend_target;
    end else begin
      npc = seq_pc;
    end
  end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage. Owns the PC, fetches over the imem req/ack bus and
// presents {pc4, inst} to the IF/ID register. A bubble (NOP_INST) is shown
// while memory has not answered; an answered-but-stalled instruction is parked
// in a hold buffer. Redirects from decode take effect after the delay slot.
module pipe_if_stage
  import pipe_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,       // asynchronous, active low
  input  logic              nostall,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       bpc,
  input  logic [31:0]       rpc,
  input  logic [31:0]       jpc,
  pipe_if_stage_if.master   imem,
  output logic [31:0]       pc4,
  output logic [31:0]       inst
);

  if_state_e   state_reg;
  if_state_e   state_next;
  logic [31:0] pc_reg;
  logic [31:0] buf_reg;
  logic        pend_valid_reg;
  logic [31:0] pend_target_reg;

  logic        consume;
  logic        redirect;
  logic [31:0] sel_target;
  logic [31:0] npc;

  pipe_npc_mux u_npc_mux (
    .pcsource    (pcsource),
    .bpc         (bpc),
    .rpc         (rpc),
    .jpc         (jpc),
    .pc          (pc_reg),
    .pend_valid  (pend_valid_reg),
    .pend_target (pend_target_reg),
    .redirect    (redirect),
    .sel_target  (sel_target),
    .npc         (npc)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, consume decision and presented outputs
  always_comb begin
    state_next = state_reg;
    consume    = 1'b0;
    imem.req   = 1'b0;
    imem.addr  = pc_reg;
    pc4        = pc_reg + 32'd4;
    inst       = NOP_INST;
    case (state_reg)
      ST_FETCH: begin
        imem.req = 1'b1;
        if (imem.ack) begin
          inst    = imem.rdata;
          consume = nostall;
          if (!nostall) begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        inst    = buf_reg;
        consume = nostall;
        if (nostall) begin
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // PC advances only when IF/ID takes the presented instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
    end else if (consume) begin
      pc_reg <= npc;
    end
  end

  // Park an answered instruction that IF/ID could not take
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_reg <= NOP_INST;
    end else if (state_reg == ST_FETCH && imem.ack && !nostall) begin
      buf_reg <= imem.rdata;
    end
  end

  // Remember a redirect that arrived while the delay slot was not yet consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= 32'h0000_0000;
    end else if (consume) begin
      pend_valid_reg  <= 1'b0;
    end else if (nostall && redirect) begin
      pend_valid_reg  <= 1'b1;
      pend_target_reg <= sel_target;
    end
  end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: directed vector table, hand-written reset/wrap
// sequences, then randomized traffic against a queue-based reference model.
module tb_pipe_if_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        nostall;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] rpc;
  logic [31:0] jpc;
  logic [31:0] pc4;
  logic [31:0] inst;

  pipe_if_stage_if imem_bus ();

  pipe_if_stage dut (
    .clk      (clk),
    .rst      (rst),
    .nostall  (nostall),
    .pcsource (pcsource),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .imem     (imem_bus.master),
    .pc4      (pc4),
    .inst     (inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ns;
    logic [1:0]  ps;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc4;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Put the selected target on its own source bus; the other buses carry junk
  task automatic drive(input logic ns, input logic [1:0] ps, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rd);
    nostall        = ns;
    pcsource       = ps;
    bpc            = (ps == 2'b01) ? tgt : 32'hB0B0_0001;
    rpc            = (ps == 2'b10) ? tgt : 32'hC0C0_0002;
    jpc            = (ps == 2'b11) ? tgt : 32'hD0D0_0003;
    imem_bus.ack   = ack;
    imem_bus.rdata = rd;
  endtask

  // One cycle: drive at negedge, compare 1 ns later, before the rising edge
  task automatic step(input string name, input logic ns, input logic [1:0] ps,
                      input logic [31:0] tgt, input logic ack, input logic [31:0] rd,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_pc4, input logic [31:0] e_inst);
    @(negedge clk);
    drive(ns, ps, tgt, ack, rd);
    #1;
    check({name, ".req"},  {31'd0, imem_bus.req}, {31'd0, e_req});
    check({name, ".addr"}, imem_bus.addr, e_addr);
    check({name, ".pc4"},  pc4, e_pc4);
    check({name, ".inst"}, inst, e_inst);
    $display("%s ns=%0d ps=%0d ack=%0d req=%0d addr=%h pc4=%h inst=%h",
             name, ns, ps, ack, imem_bus.req, imem_bus.addr, pc4, inst);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model state: PC, parked instruction, remembered redirect
  logic [31:0] m_pc;
  logic [31:0] m_held[$];
  logic [31:0] m_redir[$];

  initial begin
    logic        r_ns;
    logic        r_ack;
    logic        r_live;
    logic [1:0]  r_ps;
    logic [31:0] r_tgt;
    logic [31:0] r_rd;
    logic        e_req;
    logic [31:0] e_inst;

    rst = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("reset.req",  {31'd0, imem_bus.req}, 32'd1);
    check("reset.addr", imem_bus.addr, RST_PC);
    check("reset.pc4",  pc4, RST_PC + 32'd4);
    check("reset.inst", inst, NOP);
    @(negedge clk);
    rst = 1'b1;

    // ns, ps, tgt, ack, rdata | req, addr, pc4, inst
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b1, 32'h1111_1111, 1'b1, 32'h0040_0000, 32'h0040_0004, 32'h1111_1111});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b1, 32'h2222_2222, 1'b1, 32'h0040_0004, 32'h0040_0008, 32'h2222_2222});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b0, 32'hDEAD_0001, 1'b1, 32'h0040_0008, 32'h0040_000C, NOP});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b0, 32'hDEAD_0002, 1'b1, 32'h0040_0008, 32'h0040_000C, NOP});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b0, 32'hDEAD_0003, 1'b1, 32'h0040_0008, 32'h0040_000C, NOP});
    vq.push_back('{1'b0, 2'd0, 32'h0,        1'b1, 32'h8C22_0004, 1'b1, 32'h0040_0008, 32'h0040_000C, 32'h8C22_0004});
    vq.push_back('{1'b0, 2'd0, 32'h0,        1'b0, 32'hDEAD_0004, 1'b0, 32'h0040_0008, 32'h0040_000C, 32'h8C22_0004});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b0, 32'hDEAD_0005, 1'b0, 32'h0040_0008, 32'h0040_000C, 32'h8C22_0004});
    vq.push_back('{1'b1, 2'd1, 32'h0040_0100, 1'b1, 32'h3333_3333, 1'b1, 32'h0040_000C, 32'h0040_0010, 32'h3333_3333});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b1, 32'h4444_4444, 1'b1, 32'h0040_0100, 32'h0040_0104, 32'h4444_4444});
    vq.push_back('{1'b1, 2'd1, 32'h0040_0200, 1'b0, 32'hDEAD_0006, 1'b1, 32'h0040_0104, 32'h0040_0108, NOP});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b0, 32'hDEAD_0007, 1'b1, 32'h0040_0104, 32'h0040_0108, NOP});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b1, 32'h5555_5555, 1'b1, 32'h0040_0104, 32'h0040_0108, 32'h5555_5555});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b1, 32'h6666_6666, 1'b1, 32'h0040_0200, 32'h0040_0204, 32'h6666_6666});
    vq.push_back('{1'b0, 2'd2, 32'h0050_0000, 1'b0, 32'hDEAD_0008, 1'b1, 32'h0040_0204, 32'h0040_0208, NOP});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b1, 32'h7777_7777, 1'b1, 32'h0040_0204, 32'h0040_0208, 32'h7777_7777});
    vq.push_back('{1'b1, 2'd0, 32'h0,        1'b1, 32'h8888_8888, 1'b1, 32'h0040_0208, 32'h0040_020C, 32'h8888_8888});

    foreach (vq[i]) begin
      step($sformatf("vec%0d", i), vq[i].ns, vq[i].ps, vq[i].tgt, vq[i].ack, vq[i].rdata,
           vq[i].exp_req, vq[i].exp_addr, vq[i].exp_pc4, vq[i].exp_inst);
    end

    // Reset while in HOLD with a redirect pending: both must be forgotten
    do_reset();
    step("hr.pend", 1'b1, 2'd3, 32'h1234_5678, 1'b0, 32'h0,          1'b1, RST_PC, RST_PC + 4, NOP);
    step("hr.park", 1'b0, 2'd0, 32'h0,         1'b1, 32'hAABB_CCDD,  1'b1, RST_PC, RST_PC + 4, 32'hAABB_CCDD);
    step("hr.hold", 1'b0, 2'd0, 32'h0,         1'b0, 32'h0,          1'b0, RST_PC, RST_PC + 4, 32'hAABB_CCDD);
    #2 rst = 1'b0;
    #1;
    check("hr.rst.req",  {31'd0, imem_bus.req}, 32'd1);
    check("hr.rst.addr", imem_bus.addr, RST_PC);
    check("hr.rst.inst", inst, NOP);
    $display("hr.rst async reset in HOLD req=%0d addr=%h inst=%h", imem_bus.req, imem_bus.addr, inst);
    @(negedge clk);
    rst = 1'b1;
    step("hr.fetch", 1'b1, 2'd0, 32'h0, 1'b1, 32'h0101_0101, 1'b1, RST_PC,         RST_PC + 4, 32'h0101_0101);
    step("hr.seq",   1'b1, 2'd0, 32'h0, 1'b0, 32'h0,         1'b1, RST_PC + 32'd4, RST_PC + 8, NOP);

    // PC wrap at the top of the address space
    step("wrap.jmp", 1'b1, 2'd3, 32'hFFFF_FFFC, 1'b1, 32'h0202_0202, 1'b1, RST_PC + 32'd4, RST_PC + 8, 32'h0202_0202);
    step("wrap.top", 1'b1, 2'd0, 32'h0, 1'b1, 32'h0303_0303, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0303_0303);
    step("wrap.zero", 1'b1, 2'd0, 32'h0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 32'h0000_0004, NOP);

    // Randomized traffic against the reference model
    do_reset();
    m_pc = RST_PC;
    m_held.delete();
    m_redir.delete();
    for (int c = 0; c < 600; c++) begin
      r_ns   = ($urandom_range(0, 3) != 0);
      r_ps   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      r_tgt  = $urandom;
      r_rd   = $urandom;
      r_ack  = (m_held.size() == 0) && ($urandom_range(0, 2) != 0);
      e_req  = (m_held.size() == 0);
      if (m_held.size() != 0)  e_inst = m_held[0];
      else if (r_ack)          e_inst = r_rd;
      else                     e_inst = NOP;
      step($sformatf("rnd%0d", c), r_ns, r_ps, r_tgt, r_ack, r_rd, e_req, m_pc, m_pc + 32'd4, e_inst);
      // Advance the model: a presented instruction is taken when IF/ID is not stalled
      r_live = r_ns && (r_ps != 2'd0);
      if (r_ns && (m_held.size() != 0 || r_ack)) begin
        if (r_live)                  m_pc = r_tgt;
        else if (m_redir.size() != 0) m_pc = m_redir[0];
        else                         m_pc = m_pc + 32'd4;
        m_held.delete();
        m_redir.delete();
      end else begin
        if (r_ack && m_held.size() == 0) m_held.push_back(r_rd);
        if (r_live) begin
          m_redir.delete();
          m_redir.push_back(r_tgt);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
